seq_det_sched: RTL and testbench

SEQ_DET_SCHED -- requirements
Module: seq_det_sched

---
 rtl/seq_det_pkg.sv | 13 +
 rtl/seq_det_core.sv | 26 ++
 rtl/seq_det_sched.sv | 115 +++++++++++
 tb/tb_seq_det_sched.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// seq_det_pkg: shared constants for the time-shared 1011 sequence detector.
// Holds the 3-bit detector state width and the S0..S4 state encodings.
package seq_det_pkg;

   localparam int STATE_W = 3;

   localparam logic [2:0] S0 = 3'd0;
   localparam logic [2:0] S1 = 3'd1;
   localparam logic [2:0] S2 = 3'd2;
   localparam logic [2:0] S3 = 3'd3;
   localparam logic [2:0] S4 = 3'd4;

endpackage

// File: rtl/seq_det_core.sv
// seq_det_core: combinational next-state / hit logic for the 1011 detector.
// Ports: state (current), in (serial bit) -> next_state, hit (entering S4).
module seq_det_core
   import seq_det_pkg::*;
(
   input  logic [STATE_W-1:0] state,
   input  logic               in,
   output logic [STATE_W-1:0] next_state,
   output logic               hit
);

   always_comb begin
      next_state = S0;
      case (state)
         S0:      next_state = in ? S1 : S0;
         S1:      next_state = in ? S1 : S2;
         S2:      next_state = in ? S3 : S0;
         S3:      next_state = in ? S4 : S2;
         S4:      next_state = in ? S1 : S2;
         default: next_state = S0;
      endcase
   end

   assign hit = (next_state == S4);

endmodule

// File: rtl/seq_det_sched.sv
// seq_det_sched: round-robin scheduler sharing one 1011 detector over NCH
// serial channels. Ports: clk, rst (async, active-high), clr (sync clear),
// bit_valid/bit_data/bit_ready per channel, match pulses, match_cnt counts.
// Optional counters built only with macro SEQ_DET_SCHED_CNT_EN defined.
module seq_det_sched
   import seq_det_pkg::*;
#(
   parameter int NCH   = 4,
   parameter int CNT_W = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 clr,
   input  logic [NCH-1:0]       bit_valid,
   input  logic [NCH-1:0]       bit_data,
   output logic [NCH-1:0]       bit_ready,
   output logic [NCH-1:0]       match,
   output logic [NCH*CNT_W-1:0] match_cnt
);

   localparam int PTR_W = (NCH > 1) ? $clog2(NCH) : 1;

   logic [PTR_W-1:0]   r_ptr;
   logic [STATE_W-1:0] r_state [NCH];
   logic [NCH-1:0]     r_match;

   logic               w_any;
   logic [PTR_W-1:0]   w_idx;
   logic               w_xfer;
   logic [PTR_W-1:0]   w_ptr_nxt;
   logic [STATE_W-1:0] w_cur;
   logic [STATE_W-1:0] w_nxt;
   logic               w_hit;

   // Search from r_ptr upward, wrapping at NCH; first valid wins.
   always_comb begin
      logic [PTR_W:0] v_sum;
      w_any = 1'b0;
      w_idx = '0;
      v_sum = '0;
      for (int i = 0; i < NCH; i++) begin
         v_sum = {1'b0, r_ptr} + (PTR_W+1)'(i);
         if (v_sum >= (PTR_W+1)'(NCH))
            v_sum = v_sum - (PTR_W+1)'(NCH);
         if (!w_any && bit_valid[v_sum[PTR_W-1:0]]) begin
            w_any = 1'b1;
            w_idx = v_sum[PTR_W-1:0];
         end
      end
   end

   // Grants are suppressed during reset and clear.
   assign w_xfer = w_any & ~clr & ~rst;

   always_comb begin
      bit_ready = '0;
      if (w_xfer)
         bit_ready[w_idx] = 1'b1;
   end

   assign w_ptr_nxt = (w_idx == PTR_W'(NCH-1)) ? '0 : w_idx + 1'b1;
   assign w_cur     = r_state[w_idx];

   seq_det_core u_core (
      .state      (w_cur),
      .in         (bit_data[w_idx]),
      .next_state (w_nxt),
      .hit        (w_hit)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ptr   <= '0;
         r_match <= '0;
         for (int i = 0; i < NCH; i++)
            r_state[i] <= S0;
      end else if (clr) begin
         r_ptr   <= '0;
         r_match <= '0;
         for (int i = 0; i < NCH; i++)
            r_state[i] <= S0;
      end else begin
         r_match <= '0;
         if (w_xfer) begin
            r_state[w_idx] <= w_nxt;
            r_match[w_idx] <= w_hit;
            r_ptr          <= w_ptr_nxt;
         end
      end
   end

   assign match = r_match;

`ifdef SEQ_DET_SCHED_CNT_EN
   logic [NCH*CNT_W-1:0] r_cnt;

   // Saturating per-channel count, bumped on the edge that sets match.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (clr) begin
         r_cnt <= '0;
      end else if (w_xfer && w_hit &&
                   (r_cnt[w_idx*CNT_W +: CNT_W] != {CNT_W{1'b1}})) begin
         r_cnt[w_idx*CNT_W +: CNT_W] <=
            r_cnt[w_idx*CNT_W +: CNT_W] + 1'b1;
      end
   end

   assign match_cnt = r_cnt;
`else
   assign match_cnt = '0;
`endif

endmodule

// File: tb/tb_seq_det_sched.sv
// tb_seq_det_sched: scoreboard bench for seq_det_sched (NCH=4).
// Runs CNT_W=8 and CNT_W=2 instances side by side on shared stimulus.
module tb_seq_det_sched;

`ifdef SEQ_DET_SCHED_CNT_EN
   localparam bit CNT_ON = 1'b1;
`else
   localparam bit CNT_ON = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        clr;
   logic [3:0]  bit_valid;
   logic [3:0]  bit_data;
   logic [3:0]  bit_ready;
   logic [3:0]  match;
   logic [31:0] match_cnt;
   logic [3:0]  bit_ready2;
   logic [3:0]  match2;
   logic [7:0]  match_cnt2;

   int n_chk  = 0;
   int n_fail = 0;

   typedef struct {
      int         ch;
      logic [7:0] c8;
      logic [1:0] c2;
   } exp_t;

   exp_t q[$];
   exp_t me;

   always #5 clk = ~clk;

   seq_det_sched #(.NCH(4), .CNT_W(8)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .clr       (clr),
      .bit_valid (bit_valid),
      .bit_data  (bit_data),
      .bit_ready (bit_ready),
      .match     (match),
      .match_cnt (match_cnt)
   );

   seq_det_sched #(.NCH(4), .CNT_W(2)) u_dut2 (
      .clk       (clk),
      .rst       (rst),
      .clr       (clr),
      .bit_valid (bit_valid),
      .bit_data  (bit_data),
      .bit_ready (bit_ready2),
      .match     (match2),
      .match_cnt (match_cnt2)
   );

   function automatic logic [7:0] x8(input int v);
      return CNT_ON ? 8'(v) : 8'h0;
   endfunction

   function automatic logic [1:0] x2(input int v);
      return CNT_ON ? 2'(v) : 2'h0;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic chk_cnt(input logic [31:0] e8, input logic [7:0] e2);
      chk("cnt8", match_cnt, CNT_ON ? e8 : 32'h0);
      chk("cnt2", {24'h0, match_cnt2}, CNT_ON ? {24'h0, e2} : 32'h0);
   endtask

   // Called at a negedge; offers one bit on ch, returns at next negedge.
   task automatic send(input int ch, input logic b, input bit m,
                       input int c8, input int c2);
      exp_t e;
      bit_valid = 4'(1 << ch);
      bit_data  = b ? 4'(1 << ch) : 4'h0;
      if (m) begin
         e.ch = ch;
         e.c8 = x8(c8);
         e.c2 = x2(c2);
         q.push_back(e);
      end
      #1;
      chk("ready", {28'h0, bit_ready}, {28'h0, 4'(1 << ch)});
      chk("ready2", {28'h0, bit_ready2}, {28'h0, 4'(1 << ch)});
      @(negedge clk);
      bit_valid = 4'h0;
      bit_data  = 4'h0;
   endtask

   task automatic do_clr();
      clr       = 1'b1;
      bit_valid = 4'h0;
      @(negedge clk);
      clr = 1'b0;
   endtask

   // Monitor: every match pulse must line up with the queue head.
   always @(negedge clk) begin
      if (!rst && (match != 4'h0 || match2 != 4'h0)) begin
         n_chk++;
         if (q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_match: got %b want none at %0t",
                     match, $time);
         end else begin
            me = q.pop_front();
            if (match !== 4'(1 << me.ch) || match2 !== 4'(1 << me.ch) ||
                match_cnt[me.ch*8 +: 8] !== me.c8 ||
                match_cnt2[me.ch*2 +: 2] !== me.c2) begin
               n_fail++;
               $display("FAIL match_ch%0d: got m=%b m2=%b c8=%0d c2=%0d want ch%0d c8=%0d c2=%0d at %0t",
                        me.ch, match, match2, match_cnt[me.ch*8 +: 8],
                        match_cnt2[me.ch*2 +: 2], me.ch, me.c8, me.c2,
                        $time);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] d_bits;
      logic [3:0]  pat;
      int          k;

      rst       = 1'b1;
      clr       = 1'b0;
      bit_valid = 4'hF;
      bit_data  = 4'hF;
      repeat (2) @(negedge clk);
      chk("rst_ready", {28'h0, bit_ready}, 32'h0);
      chk("rst_match", {28'h0, match}, 32'h0);
      chk_cnt(32'h0, 8'h0);
      rst       = 1'b0;
      bit_valid = 4'h0;
      bit_data  = 4'h0;
      @(negedge clk);

      // ch0 1011
      send(0, 1'b1, 0, 0, 0);
      send(0, 1'b0, 0, 0, 0);
      send(0, 1'b1, 0, 0, 0);
      send(0, 1'b1, 1, 1, 1);
      @(negedge clk);
      chk_cnt(32'h0000_0001, 8'h01);

      // ch1 1011011 overlapping
      send(1, 1'b1, 0, 0, 0);
      send(1, 1'b0, 0, 0, 0);
      send(1, 1'b1, 0, 0, 0);
      send(1, 1'b1, 1, 1, 1);
      send(1, 1'b0, 0, 0, 0);
      send(1, 1'b1, 0, 0, 0);
      send(1, 1'b1, 1, 2, 2);
      @(negedge clk);
      chk_cnt(32'h0000_0201, 8'h09);
      chk("q_empty_b", q.size(), 0);

      // all channels valid: RR order 0,1,2,3 with isolated state
      do_clr();
      chk_cnt(32'h0, 8'h0);
      pat = 4'b1011;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            bit_valid = 4'hF;
            bit_data  = pat[3-r] ? 4'hF : 4'h0;
            if (r == 3) begin
               me.ch = c;
               me.c8 = x8(1);
               me.c2 = x2(1);
               q.push_back(me);
            end
            #1;
            chk("rr_grant", {28'h0, bit_ready}, {28'h0, 4'(1 << c)});
            @(negedge clk);
         end
      end
      bit_valid = 4'h0;
      bit_data  = 4'h0;
      @(negedge clk);
      chk_cnt(32'h0101_0101, 8'h55);
      chk("q_empty_c", q.size(), 0);

      // ch2: five overlapping matches, CNT_W=2 saturates at 3
      do_clr();
      d_bits = 16'b1011_0110_1101_1011;
      k = 0;
      for (int i = 0; i < 16; i++) begin
         if (i == 3 || i == 6 || i == 9 || i == 12 || i == 15) begin
            k++;
            send(2, d_bits[15-i], 1, k, (k > 3) ? 3 : k);
         end else begin
            send(2, d_bits[15-i], 0, 0, 0);
         end
      end
      @(negedge clk);
      chk_cnt(32'h0005_0000, 8'h30);

      // clr while ch0 offers final 1
      do_clr();
      send(0, 1'b1, 0, 0, 0);
      send(0, 1'b0, 0, 0, 0);
      send(0, 1'b1, 0, 0, 0);
      clr       = 1'b1;
      bit_valid = 4'h1;
      bit_data  = 4'h1;
      #1;
      chk("clr_ready", {28'h0, bit_ready}, 32'h0);
      @(negedge clk);
      clr       = 1'b0;
      bit_valid = 4'h0;
      bit_data  = 4'h0;
      chk("clr_match", {28'h0, match}, 32'h0);
      chk_cnt(32'h0, 8'h0);
      // from S0 a single 1 cannot match; 0,1,1 then completes 1011
      send(0, 1'b1, 0, 0, 0);
      send(0, 1'b0, 0, 0, 0);
      send(0, 1'b1, 0, 0, 0);
      send(0, 1'b1, 1, 1, 1);
      @(negedge clk);
      chk_cnt(32'h0000_0001, 8'h01);

      // rst after partial 101 on ch3
      send(3, 1'b1, 0, 0, 0);
      send(3, 1'b0, 0, 0, 0);
      send(3, 1'b1, 0, 0, 0);
      rst       = 1'b1;
      bit_valid = 4'h8;
      bit_data  = 4'h8;
      #1;
      chk("rst2_ready", {28'h0, bit_ready}, 32'h0);
      chk_cnt(32'h0, 8'h0);
      @(negedge clk);
      rst       = 1'b0;
      bit_valid = 4'h0;
      bit_data  = 4'h0;
      @(negedge clk);
      send(3, 1'b1, 0, 0, 0);
      send(3, 1'b1, 0, 0, 0);
      send(3, 1'b0, 0, 0, 0);
      send(3, 1'b1, 0, 0, 0);
      send(3, 1'b1, 1, 1, 1);
      repeat (2) @(negedge clk);
      chk_cnt(32'h0100_0000, 8'h40);
      chk("q_empty_end", q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
